gpio_top: RTL
=============

// Module: gpio_top
// PURPOSE
//  Memory-mapped GPIO peripheral that hangs off the SoC data-bus interconnect beside the UART, SPI and CLINT slaves.
//  - Decodes its own register window and returns registered read data with a one-cycle ack.
//  - Drives the output-data and output-enable pins.
//  - Synchronises the input pins.
//  - Raises a level interrupt request from per-pin rising-edge or level events; this request feeds a PLIC source.
// PARAMETERS
//  GPIO_WIDTH   8   number of GPIO pins (1..32)
//  SYNC_STAGES  2   input synchroniser depth (>=2)
//  ADDR_W       8   byte-address bits decoded inside the window
// PORTS
//  clk              in   1           clock, single domain
//  rst_n            in   1           reset, asynchronous assert, active-low
//  dbus_req_i       in   1           bus request valid
//  gpio_sel_i       in   1           address-decoder select for this block
//  dbus_w_en_i      in   1           1 = write, 0 = read
//  dbus_addr_i      in   ADDR_W      byte address; [1:0] ignored
//  dbus_sel_byte_i  in   4           write byte enables
//  dbus_w_data_i    in   32          write data
//  gpio2dbus_rdata_o out 32          read data, valid only while ack is high
//  gpio2dbus_ack_o  out  1           one-cycle transfer ack
//  gpio_irq_o       out  1           interrupt request to PLIC
//  gpio_in_i        in   GPIO_WIDTH  asynchronous pin inputs
//  gpio_out_o       out  GPIO_WIDTH  pin output values
//  gpio_oe_o        out  GPIO_WIDTH  pin output enables (1 = drive)
// BEHAVIOUR
//  Reset: every register, every output and all synchroniser flops go to 0. Asserting reset mid-transfer aborts it; no ack is produced.
//  Register map (word offsets):
//    0x00 OUT   rw
//    0x04 OE    rw
//    0x08 IN    ro (synchronised value)
//    0x0C IE    rw
//    0x10 TYPE  rw (1 = rising edge, 0 = level-high)
//    0x14 PEND  rw1c
//  Bits at and above GPIO_WIDTH read 0; writes to them are ignored.
//  Bus FSM has two states:
//    IDLE -> ACK when (dbus_req_i & gpio_sel_i); address, data and byte enables are captured in that cycle.
//    ACK  -> IDLE unconditionally.
//  Ack behaviour:
//    - ack is high only in ACK, so latency is exactly 1 cycle and a new request is accepted earliest in the cycle after ack.
//    - A request seen in ACK is not sampled.
//    - Write side effects land on the IDLE->ACK edge.
//    - Read data is registered and returned in ACK.
//  Unmapped offsets and writes to IN: reads return 0 and writes are dropped; ack is still generated.
//  Byte enables: each set bit of dbus_sel_byte_i updates its byte lane. PEND W1C is also byte-masked.
//  Synchroniser and edge detection:
//    - sync = gpio_in_i after SYNC_STAGES flops.
//    - One additional flop holds the previous sync value for edge detection.
//    - Input-to-IN read latency is SYNC_STAGES cycles.
//  Event per pin:
//    - TYPE=1: sync & ~prev.
//    - TYPE=0: sync (re-asserts while high).
//  Pending update per pin, each cycle: PEND <= (PEND & ~w1c_mask) | event.
//    - The event is recorded even when IE is 0.
//    - When a set and a clear hit the same bit in the same cycle, the set wins.
//  gpio_irq_o is registered: |(PEND & IE) delayed one cycle.
// TESTING
//  1. Write OE=0xFF, then write OUT=0xA5 with sel_byte=4'b0001 -> ack 1 cycle later; gpio_oe_o=0xFF; gpio_out_o=0xA5; read OUT returns 0x000000A5.
//  2. Write 0xFFFFFFFF to OUT with GPIO_WIDTH=8 -> read returns 0x000000FF. Read 0x18 -> returns 0 with ack. Write IN -> IN unchanged.
//  3. TYPE[3]=1, IE[3]=1, gpio_in_i[3] 0->1 -> PEND=0x08 after SYNC_STAGES+1 cycles; gpio_irq_o high one cycle later. Write PEND=0x08 -> both clear and stay clear while the pin holds 1.
//  4. TYPE[0]=0, IE[0]=0, pin 0 held high -> PEND[0]=1 and irq stays 0. Write PEND=0x01 -> PEND[0] reads 1 again, because the set wins. Then set IE=1 -> irq asserts.
//  5. Hold req&sel high for 4 cycles -> ack on cycles 2 and 4 only. Assert rst_n=0 in the capture cycle -> no ack, and OUT, OE and PEND read 0 after reset.

Source files
------------

// File: rtl/gpio_top.sv
// Memory-mapped GPIO slave: register window with one-cycle registered ack,
// output/enable pins, synchronised inputs and a pending-event interrupt.
module gpio_top #(
  parameter int GPIO_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dbus_req_i,
  input  logic                  gpio_sel_i,
  input  logic                  dbus_w_en_i,
  input  logic [ADDR_W-1:0]     dbus_addr_i,
  input  logic [3:0]            dbus_sel_byte_i,
  input  logic [31:0]           dbus_w_data_i,
  output logic [31:0]           gpio2dbus_rdata_o,
  output logic                  gpio2dbus_ack_o,
  output logic                  gpio_irq_o,
  input  logic [GPIO_WIDTH-1:0] gpio_in_i,
  output logic [GPIO_WIDTH-1:0] gpio_out_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  localparam logic [ADDR_W-1:0] A_OUT  = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_OE   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_IN   = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_IE   = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_TYPE = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_PEND = ADDR_W'(32'h14);

  logic [0:0]                                 state_q, state_d;
  logic [GPIO_WIDTH-1:0]                      out_q, out_d, oe_q, oe_d, ie_q, ie_d;
  logic [GPIO_WIDTH-1:0]                      type_q, type_d, pend_q, pend_d;
  logic [GPIO_WIDTH-1:0]                      prev_q, prev_d;
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0]     sync_q, sync_d;
  logic [31:0]                                rdata_q, rdata_d;
  logic                                       irq_q, irq_d;

  logic                  accept, wr;
  logic [ADDR_W-1:0]     off;
  logic [31:0]           bmask32, rd;
  logic [GPIO_WIDTH-1:0] wmask, wdata, sync, evt, w1c;
  logic                  unused_bits;

  assign unused_bits = ^{dbus_addr_i[1:0], dbus_w_data_i, bmask32};

  always_comb begin
    accept = (state_q == S_IDLE) && dbus_req_i && gpio_sel_i;
    wr     = accept && dbus_w_en_i;
    off    = {dbus_addr_i[ADDR_W-1:2], 2'b00};
    for (int b = 0; b < 4; b++) bmask32[8*b +: 8] = {8{dbus_sel_byte_i[b]}};
    wmask  = bmask32[GPIO_WIDTH-1:0];
    wdata  = dbus_w_data_i[GPIO_WIDTH-1:0];

    sync_d[0] = gpio_in_i;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    sync   = sync_q[SYNC_STAGES-1];
    prev_d = sync;
    // Edge pins fire once per rising edge; level pins fire every cycle they are high
    evt    = (type_q & sync & ~prev_q) | (~type_q & sync);

    out_d  = out_q;
    oe_d   = oe_q;
    ie_d   = ie_q;
    type_d = type_q;
    w1c    = '0;
    if (wr) begin
      case (off)
        A_OUT:   out_d  = (out_q  & ~wmask) | (wdata & wmask);
        A_OE:    oe_d   = (oe_q   & ~wmask) | (wdata & wmask);
        A_IE:    ie_d   = (ie_q   & ~wmask) | (wdata & wmask);
        A_TYPE:  type_d = (type_q & ~wmask) | (wdata & wmask);
        A_PEND:  w1c    = wdata & wmask;
        default: ;
      endcase
    end
    pend_d = (pend_q & ~w1c) | evt;

    rd = '0;
    case (off)
      A_OUT:   rd[GPIO_WIDTH-1:0] = out_q;
      A_OE:    rd[GPIO_WIDTH-1:0] = oe_q;
      A_IN:    rd[GPIO_WIDTH-1:0] = sync;
      A_IE:    rd[GPIO_WIDTH-1:0] = ie_q;
      A_TYPE:  rd[GPIO_WIDTH-1:0] = type_q;
      A_PEND:  rd[GPIO_WIDTH-1:0] = pend_q;
      default: ;
    endcase
    rdata_d = (accept && !dbus_w_en_i) ? rd : '0;

    state_d = accept ? S_ACK : S_IDLE;
    irq_d   = |(pend_q & ie_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      oe_q    <= '0;
      ie_q    <= '0;
      type_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      sync_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      ie_q    <= ie_d;
      type_q  <= type_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      sync_q  <= sync_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign gpio2dbus_ack_o   = (state_q == S_ACK);
  assign gpio2dbus_rdata_o = rdata_q;
  assign gpio_irq_o        = irq_q;
  assign gpio_out_o        = out_q;
  assign gpio_oe_o         = oe_q;

endmodule
